// File: rtl/vec_match_pkg.sv
// Shared types for the image-vs-library vector match scheduler.
// Optional threshold reporting is enabled by defining VEC_MATCH_SCHED_THRESH_EN.
package vec_match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned IMG_VEC_N_DEF = 64;
  localparam int unsigned LIB_VEC_N_DEF = 256;
  localparam int unsigned SCORE_W_DEF   = 16;

`ifdef VEC_MATCH_SCHED_THRESH_EN
  localparam int unsigned HIT_W = 1;
`else
  localparam int unsigned HIT_W = 0;
`endif

  // Address width for a vector count; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Result record width, field order {img_idx, lib_idx, score[, hit]}.
  function automatic int unsigned rec_w(input int unsigned iw, input int unsigned lw,
                                        input int unsigned sw);
    return iw + lw + sw + HIT_W;
  endfunction

endpackage

// File: rtl/vec_match_resbuf.sv
// Two-entry valid/ready result FIFO with registered head and occupancy output.
module vec_match_resbuf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [1:0]        r_cnt;
  logic              r_valid;
  logic              w_pop;

  assign w_pop   = r_valid && i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_head;
  assign o_count = r_cnt;

  // Head is the output register; tail only holds the second entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_cnt   <= 2'd0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_cnt   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (i_push) begin
            r_head  <= i_data;
            r_cnt   <= 2'd1;
            r_valid <= 1'b1;
          end
        end
        2'd1: begin
          case ({i_push, w_pop})
            2'b11: r_head <= i_data;
            2'b10: begin
              r_tail <= i_data;
              r_cnt  <= 2'd2;
            end
            2'b01: begin
              r_cnt   <= 2'd0;
              r_valid <= 1'b0;
            end
            default: ;
          endcase
        end
        2'd2: begin
          if (w_pop) begin
            r_head <= r_tail;
            if (i_push) begin
              r_tail <= i_data;
            end else begin
              r_cnt <= 2'd1;
            end
          end
        end
        default: begin
          r_cnt   <= 2'd0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/vec_match_sched.sv
// Issues (image, library) address pairs, reduces the returned scores to one
// best match per image row. Optional macro: VEC_MATCH_SCHED_THRESH_EN.
module vec_match_sched
  import vec_match_pkg::*;
#(
  parameter  int unsigned IMG_VEC_N = IMG_VEC_N_DEF,
  parameter  int unsigned LIB_VEC_N = LIB_VEC_N_DEF,
  parameter  int unsigned SCORE_W   = SCORE_W_DEF,
  localparam int unsigned IMG_W     = addr_w(IMG_VEC_N),
  localparam int unsigned LIB_W     = addr_w(LIB_VEC_N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [IMG_W-1:0]   img_addr,
  output logic [LIB_W-1:0]   lib_addr,
  input  logic               score_valid_i,
  input  logic [SCORE_W-1:0] score_i,
`ifdef VEC_MATCH_SCHED_THRESH_EN
  input  logic [SCORE_W-1:0] thresh,
  output logic               res_hit,
`endif
  output logic               res_valid,
  input  logic               res_ready,
  output logic [IMG_W-1:0]   res_img_idx,
  output logic [LIB_W-1:0]   res_lib_idx,
  output logic [SCORE_W-1:0] res_score
);

  localparam logic [IMG_W-1:0] IMG_LAST = IMG_W'(IMG_VEC_N - 1);
  localparam logic [LIB_W-1:0] LIB_LAST = LIB_W'(LIB_VEC_N - 1);

  typedef struct packed {
    logic [IMG_W-1:0]   img_idx;
    logic [LIB_W-1:0]   lib_idx;
    logic [SCORE_W-1:0] score;
`ifdef VEC_MATCH_SCHED_THRESH_EN
    logic               hit;
`endif
  } res_rec_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_busy;
  logic               r_done;
  logic               r_rd_en;
  logic [IMG_W-1:0]   r_img_addr;
  logic [LIB_W-1:0]   r_lib_addr;
  logic [1:0]         r_rows_inflight;
  logic [IMG_W-1:0]   r_rx_img;
  logic [LIB_W-1:0]   r_rx_lib;
  logic               r_rx_all;
  logic [SCORE_W-1:0] r_best_score;
  logic [LIB_W-1:0]   r_best_idx;

  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_rd_en_nxt;
  logic [IMG_W-1:0]   w_img_nxt;
  logic [LIB_W-1:0]   w_lib_nxt;
  logic [1:0]         w_infl_nxt;
  logic               w_issue_last;
  logic               w_row_first;
  logic               w_clear;
  logic               w_push;
  logic               w_pop;
  logic               w_last_pop;
  logic               w_res_valid;
  logic [1:0]         w_occ;
  logic               w_win;
  logic [SCORE_W-1:0] w_win_score;
  logic [LIB_W-1:0]   w_win_idx;
  res_rec_t           w_push_rec;
  res_rec_t           w_head;

  assign w_issue_last = r_rd_en && (r_img_addr == IMG_LAST) && (r_lib_addr == LIB_LAST);
  assign w_row_first  = r_rd_en && (r_lib_addr == '0);
  assign w_clear      = abort || (r_state == ST_DONE);
  assign w_push       = score_valid_i && (r_rx_lib == LIB_LAST);
  assign w_pop        = w_res_valid && res_ready;
  assign w_last_pop   = r_rx_all && w_pop && (w_occ == 2'd1) && !w_push;
  assign w_infl_nxt   = r_rows_inflight + 2'(w_row_first) - 2'(w_pop);

  // Issue pointer advances after every cycle that presented a pair.
  always_comb begin
    w_img_nxt = r_img_addr;
    w_lib_nxt = r_lib_addr;
    if (r_rd_en) begin
      if (r_lib_addr == LIB_LAST) begin
        w_lib_nxt = '0;
        w_img_nxt = (r_img_addr == IMG_LAST) ? '0 : r_img_addr + IMG_W'(1);
      end else begin
        w_lib_nxt = r_lib_addr + LIB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A row may only open while fewer than two rows hold a result slot.
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_rd_en_nxt = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_issue_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_last_pop) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end
    w_busy_nxt  = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
    w_done_nxt  = (w_state_nxt == ST_DONE);
    w_rd_en_nxt = (w_state_nxt == ST_RUN) && ((w_lib_nxt != '0) || (w_infl_nxt < 2'd2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_rd_en         <= 1'b0;
      r_img_addr      <= '0;
      r_lib_addr      <= '0;
      r_rows_inflight <= 2'd0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_rd_en <= w_rd_en_nxt;
      if (w_clear) begin
        r_img_addr      <= '0;
        r_lib_addr      <= '0;
        r_rows_inflight <= 2'd0;
      end else begin
        r_img_addr      <= w_img_nxt;
        r_lib_addr      <= w_lib_nxt;
        r_rows_inflight <= w_infl_nxt;
      end
    end
  end

  // Strict less-than keeps the lowest library index on ties.
  assign w_win       = score_i < r_best_score;
  assign w_win_score = w_win ? score_i : r_best_score;
  assign w_win_idx   = w_win ? r_rx_lib : r_best_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_img     <= '0;
      r_rx_lib     <= '0;
      r_rx_all     <= 1'b0;
      r_best_score <= '0;
      r_best_idx   <= '0;
    end else if (w_clear) begin
      r_rx_img     <= '0;
      r_rx_lib     <= '0;
      r_rx_all     <= 1'b0;
      r_best_score <= '0;
      r_best_idx   <= '0;
    end else if (score_valid_i) begin
      if (r_rx_lib == '0) begin
        r_best_score <= score_i;
        r_best_idx   <= '0;
      end else if (w_win) begin
        r_best_score <= score_i;
        r_best_idx   <= r_rx_lib;
      end
      if (r_rx_lib == LIB_LAST) begin
        r_rx_lib <= '0;
        r_rx_img <= (r_rx_img == IMG_LAST) ? '0 : r_rx_img + IMG_W'(1);
        if (r_rx_img == IMG_LAST) begin
          r_rx_all <= 1'b1;
        end
      end else begin
        r_rx_lib <= r_rx_lib + LIB_W'(1);
      end
    end
  end

  always_comb begin
    w_push_rec         = '0;
    w_push_rec.img_idx = r_rx_img;
    w_push_rec.score   = w_win_score;
`ifdef VEC_MATCH_SCHED_THRESH_EN
    w_push_rec.hit     = (w_win_score <= thresh);
    w_push_rec.lib_idx = w_push_rec.hit ? w_win_idx : '1;
`else
    w_push_rec.lib_idx = w_win_idx;
`endif
  end

  vec_match_resbuf #(
    .DATA_W ($bits(res_rec_t))
  ) u_resbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (abort),
    .i_push  (w_push),
    .i_data  (w_push_rec),
    .o_valid (w_res_valid),
    .i_ready (res_ready),
    .o_data  (w_head),
    .o_count (w_occ)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign rd_en       = r_rd_en;
  assign img_addr    = r_img_addr;
  assign lib_addr    = r_lib_addr;
  assign res_valid   = w_res_valid;
  assign res_img_idx = w_head.img_idx;
  assign res_lib_idx = w_head.lib_idx;
  assign res_score   = w_head.score;
`ifdef VEC_MATCH_SCHED_THRESH_EN
  assign res_hit     = w_head.hit;
`endif

endmodule

// File: tb/tb_vec_match_sched.sv
// Scoreboard bench for vec_match_sched with IMG=4, LIB=4 and a 3-stage score pipe.
module tb_vec_match_sched;

  localparam int unsigned IMG_N = 4;
  localparam int unsigned LIB_N = 4;
  localparam int unsigned SW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          res_ready = 1'b0;
  logic          score_valid_i = 1'b0;
  logic [SW-1:0] score_i = '0;
  logic          busy, done, rd_en, res_valid;
  logic [1:0]    img_addr, lib_addr, res_img_idx, res_lib_idx;
  logic [SW-1:0] res_score;
`ifdef VEC_MATCH_SCHED_THRESH_EN
  logic [SW-1:0] thresh = 8'hFF;
  logic          res_hit;
`endif

  typedef struct {
    int img;
    int lib;
    int score;
    bit hit;
  } exp_t;

  exp_t          exp_q[$];
  logic [SW-1:0] tbl[16];
  logic          dp_kill = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            pair_cnt = 0;
  int            done_cnt = 0;

  always #5 clk = ~clk;

  vec_match_sched #(
    .IMG_VEC_N (IMG_N),
    .LIB_VEC_N (LIB_N),
    .SCORE_W   (SW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .rd_en         (rd_en),
    .img_addr      (img_addr),
    .lib_addr      (lib_addr),
    .score_valid_i (score_valid_i),
    .score_i       (score_i),
`ifdef VEC_MATCH_SCHED_THRESH_EN
    .thresh        (thresh),
    .res_hit       (res_hit),
`endif
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_img_idx   (res_img_idx),
    .res_lib_idx   (res_lib_idx),
    .res_score     (res_score)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_row(input int r, input int a, input int b, input int c, input int d);
    tbl[r*4+0] = SW'(a);
    tbl[r*4+1] = SW'(b);
    tbl[r*4+2] = SW'(c);
    tbl[r*4+3] = SW'(d);
  endtask

  task automatic push_exp(input int img, input int lib, input int score, input bit hit);
    exp_t e;
    e.img = img; e.lib = lib; e.score = score; e.hit = hit;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) break;
      step(1);
    end
    step(5);
    chk(nm, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic load_table_a();
    set_row(0, 9, 3, 7, 5);
    set_row(1, 2, 8, 2, 1);
    set_row(2, 4, 4, 4, 4);
    set_row(3, 6, 5, 5, 9);
    push_exp(0, 1, 3, 1'b1);
    push_exp(1, 3, 1, 1'b1);
    push_exp(2, 0, 4, 1'b1);
    push_exp(3, 1, 5, 1'b1);
  endtask

  // Datapath model: scores return in issue order through a fixed pipe.
  logic          pv[3];
  logic [SW-1:0] ps[3];
  initial begin
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      ps[i] = '0;
    end
  end
  always begin
    @(posedge clk);
    #1;
    if (dp_kill || !rst_n) begin
      for (int i = 0; i < 3; i++) pv[i] = 1'b0;
      score_valid_i = 1'b0;
      score_i       = '0;
    end else begin
      pv[2] = pv[1]; ps[2] = ps[1];
      pv[1] = pv[0]; ps[1] = ps[0];
      pv[0] = rd_en; ps[0] = tbl[{img_addr, lib_addr}];
      score_valid_i = pv[2];
      score_i       = ps[2];
    end
  end

  // Monitor: pair order, done pulses, hold stability and result scoreboard.
  logic          hold = 1'b0;
  logic [1:0]    h_img, h_lib;
  logic [SW-1:0] h_score;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (start && !busy && !done) pair_cnt = 0;
      if (rd_en) begin
        chk("pair_img", 32'(img_addr), 32'(pair_cnt / LIB_N));
        chk("pair_lib", 32'(lib_addr), 32'(pair_cnt % LIB_N));
        pair_cnt++;
      end
      if (done) done_cnt++;
      if (hold) begin
        chk("hold_valid", 32'(res_valid), 32'd1);
        chk("hold_img", 32'(res_img_idx), 32'(h_img));
        chk("hold_lib", 32'(res_lib_idx), 32'(h_lib));
        chk("hold_score", 32'(res_score), 32'(h_score));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("res_img_idx", 32'(res_img_idx), 32'(e.img));
          chk("res_lib_idx", 32'(res_lib_idx), 32'(e.lib));
          chk("res_score", 32'(res_score), 32'(e.score));
`ifdef VEC_MATCH_SCHED_THRESH_EN
          chk("res_hit", 32'(res_hit), 32'(e.hit));
`endif
        end
      end
      hold    = res_valid && !res_ready;
      h_img   = res_img_idx;
      h_lib   = res_lib_idx;
      h_score = res_score;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    int found;
    for (int i = 0; i < 16; i++) tbl[i] = '0;

    // Reset state
    step(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_addr", 32'({img_addr, lib_addr}), 32'd0);
    chk("rst_res_fields", 32'({res_img_idx, res_lib_idx, res_score}), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Min search, unstalled issue of all 16 pairs
    load_table_a();
    res_ready = 1'b1;
    pulse_start();
    chk("first_rd_en", 32'(rd_en), 32'd1);
    chk("busy_run", 32'(busy), 32'd1);
    run = 0;
    for (int i = 0; i < 40; i++) begin
      if (!rd_en) break;
      run++;
      step(1);
    end
    chk("rd_en_run", 32'(run), 32'(IMG_N * LIB_N));
    wait_done("done_minsearch", 200);
    chk("pairs_minsearch", 32'(pair_cnt), 32'(IMG_N * LIB_N));
    chk("q_empty_minsearch", 32'(exp_q.size()), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Backpressure: issue must halt at row 2's first pair
    set_row(0, 5, 6, 7, 8);
    set_row(1, 9, 9, 1, 1);
    set_row(2, 3, 2, 1, 0);
    set_row(3, 255, 254, 254, 255);
    push_exp(0, 0, 5, 1'b1);
    push_exp(1, 2, 1, 1'b1);
    push_exp(2, 3, 0, 1'b1);
    push_exp(3, 1, 254, 1'b1);
    res_ready = 1'b0;
    pulse_start();
    step(30);
    chk("bp_pairs", 32'(pair_cnt), 32'd8);
    chk("bp_rd_en", 32'(rd_en), 32'd0);
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    wait_done("done_bp", 200);
    chk("pairs_bp", 32'(pair_cnt), 32'(IMG_N * LIB_N));
    chk("q_empty_bp", 32'(exp_q.size()), 32'd0);

    // start in RUN and in DRAIN is ignored
    load_table_a();
    pulse_start();
    step(4);
    pulse_start();
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (!rd_en && busy) begin
        found = 1;
        break;
      end
      step(1);
    end
    chk("drain_reached", 32'(found), 32'd1);
    pulse_start();
    wait_done("done_ignored_start", 200);
    step(10);
    chk("pairs_ignored_start", 32'(pair_cnt), 32'(IMG_N * LIB_N));
    chk("idle_after_ignored", 32'(busy), 32'd0);
    chk("q_empty_ignored", 32'(exp_q.size()), 32'd0);

    // abort mid-row 1, then a clean run
    pulse_start();
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (rd_en && img_addr == 2'd1 && lib_addr == 2'd1) begin
        found = 1;
        break;
      end
      step(1);
    end
    chk("abort_trigger", 32'(found), 32'd1);
    abort   = 1'b1;
    dp_kill = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    chk("abort_rd_en", 32'(rd_en), 32'd0);
    chk("abort_addr", 32'({img_addr, lib_addr}), 32'd0);
    step(6);
    dp_kill = 1'b0;
    chk("abort_no_result", 32'(exp_q.size()), 32'd0);
    load_table_a();
    pulse_start();
    wait_done("done_after_abort", 200);
    chk("pairs_after_abort", 32'(pair_cnt), 32'(IMG_N * LIB_N));
    chk("q_empty_after_abort", 32'(exp_q.size()), 32'd0);

`ifdef VEC_MATCH_SCHED_THRESH_EN
    // Threshold hit / miss, including the equal-to boundary
    thresh = 8'd4;
    set_row(0, 5, 3, 8, 9);
    set_row(1, 7, 6, 9, 8);
    set_row(2, 4, 9, 9, 9);
    set_row(3, 5, 5, 5, 5);
    push_exp(0, 1, 3, 1'b1);
    push_exp(1, 3, 6, 1'b0);
    push_exp(2, 0, 4, 1'b1);
    push_exp(3, 3, 5, 1'b0);
    pulse_start();
    wait_done("done_thresh", 200);
    chk("q_empty_thresh", 32'(exp_q.size()), 32'd0);
    thresh = 8'hFF;
`endif

    // Asynchronous reset mid-run
    load_table_a();
    pulse_start();
    step(3);
    dp_kill = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rd_en", 32'(rd_en), 32'd0);
    chk("arst_addr", 32'({img_addr, lib_addr}), 32'd0);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    exp_q.delete();
    step(2);
    rst_n = 1'b1;
    step(5);
    dp_kill = 1'b0;
    step(2);
    chk("arst_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_match_sched.md
# vec_match_sched

Controller for the image-vs-library vector match datapath. On `start` it issues every (image, library) address pair, image outer loop, library inner loop, to the vector BRAMs and distance unit. It consumes the in-order score stream that comes back, keeps the minimum score per image row, and hands one best-match result per image to the downstream consumer over a valid/ready port. A 2-row credit scheme keeps the score stream free of backpressure.

## Interface
- `IMG_VEC_N`, default 64: number of image vectors (≥1).
- `LIB_VEC_N`, default 256: number of library vectors (≥2).
- `SCORE_W`, default 16: distance score width, unsigned.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle launch pulse; ignored unless IDLE.
- `abort`  in  1  synchronous cancel; returns to IDLE from any state.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when the last result is accepted downstream.
- `rd_en`  out  1  address pair valid this cycle.
- `img_addr`  out  clog2(IMG_VEC_N)  image vector address.
- `lib_addr`  out  clog2(LIB_VEC_N)  library vector address.
- `score_valid_i`  in  1  score from the datapath; always accepted.
- `score_i`  in  SCORE_W  distance score.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts result.
- `res_img_idx`  out  clog2(IMG_VEC_N)  image index of the result.
- `res_lib_idx`  out  clog2(LIB_VEC_N)  library index of the best score.
- `res_score`  out  SCORE_W  best (minimum) score.

## Operation
- FSM states:
  - IDLE: `start` → RUN. All counters cleared on entry.
  - RUN: issues pairs. After the pair (IMG_VEC_N-1, LIB_VEC_N-1) is issued → DRAIN.
  - DRAIN: waits until every score has been received and the result buffer is empty → DONE.
  - DONE: asserts `done` for 1 cycle → IDLE.
- Issue counters:
  - `lib_addr` increments on each `rd_en`.
  - At LIB_VEC_N-1 it wraps to 0 and `img_addr` increments.
  - `img_addr` returns to 0 after the final pair.
- Credit rule:
  - `rows_inflight` = rows with at least one pair issued whose result has not been popped.
  - A row's first pair (`lib_addr`==0) is issued only if `rows_inflight` < 2.
  - Pairs within a row that has already started are never stalled.
- Score collection:
  - Receive-side counters `rx_lib`/`rx_img` track which pair each `score_valid_i` belongs to. The datapath returns scores in issue order with arbitrary latency ≥1.
  - The score with `rx_lib`==0 loads the best register unconditionally.
  - After that, the best register updates only when `score_i` < best. Ties keep the lower library index.
  - On `rx_lib`==LIB_VEC_N-1, {rx_img, best idx, best score} is pushed into the 2-entry result buffer. The push includes the current score if it wins.
- Result buffer:
  - Push and pop in the same cycle are legal.
  - A pop decrements `rows_inflight`. An issue of `lib_addr`==0 in the same cycle increments it, giving a net change of 0.
- `abort` clears the FSM, counters, `rows_inflight` and the buffer. Scores still in flight after an abort are the caller's responsibility and must be flushed before the next `start`.
- `start` while `busy` or during DONE: no effect.

## Timing
- All outputs are registered. Reset values: `busy`, `done`, `rd_en`, `res_valid` = 0; all address, index and score outputs = 0.
- `rd_en` first asserts the cycle after `start` is sampled.
- Without stalls, `rd_en` stays high for IMG_VEC_N·LIB_VEC_N consecutive cycles.
- `res_valid` asserts the cycle after the final score of a row is received.
- Result fields hold stable while `res_valid` && !`res_ready`.
- `done` asserts the cycle after the handshake that pops the last result.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

## Configuration
- Macro `VEC_MATCH_SCHED_THRESH_EN`.
- Defined:
  - Adds input `thresh` [SCORE_W] and output `res_hit` [1].
  - `res_hit` = (best score ≤ `thresh`), sampled at push time.
  - When `res_hit`=0, `res_lib_idx` reads all-ones.
- Undefined: neither port exists, and `res_lib_idx` is always the argmin.

## Structure
- Package `vec_match_pkg` holds:
  - the FSM state encoding (IDLE/RUN/DRAIN/DONE);
  - address width helper constants;
  - the packed result record layout {img_idx, lib_idx, score[, hit]}.
- Sub-module `vec_match_resbuf`: 2-entry valid/ready FIFO with occupancy output, instantiated once.

## Test plan
- Min search with IMG=2, LIB=4, scores row0 = 9,3,7,5 and row1 = 2,8,2,1, latency 3 → results (0,1,3) then (1,3,1), followed by one `done` pulse.
- Tie handling: row scores 4,4,4,4 → `res_lib_idx`=0, `res_score`=4.
- Backpressure: IMG=4, LIB=4, `res_ready`=0 → `rd_en` stops once row 2's first issue is pending (8 pairs issued). Raising `res_ready` resumes issue; all 4 results arrive in order.
- `start` pulsed in RUN and again in DRAIN → no restart; the pair count stays exactly IMG·LIB.
- `abort` mid-row 1 → next cycle `busy`=0, `res_valid`=0, addresses 0. A fresh `start` completes normally.
- With `VEC_MATCH_SCHED_THRESH_EN`, `thresh`=4, row best scores 3 and 6 → `res_hit` 1 then 0, `res_lib_idx` all-ones for the second result.
